// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
//
// Restoring division, one quotient bit per cycle, using a single add_sub
// instance in subtract mode. Operands are reduced to magnitudes at accept, and
// the sign is reapplied in a single FIX cycle. Divide-by-zero and signed
// overflow are answered directly at accept and skip the iteration.
//
// Ports (div_unit):
//   i_clk     in   1  clock, rising edge
//   i_rst     in   1  synchronous active-high reset
//   i_start   in   1  start request, accepted in IDLE or DONE
//   i_op      in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_rs1     in  32  dividend, sampled on the accept edge
//   i_rs2     in  32  divisor, sampled on the accept edge
//   i_flush   in   1  abort the current operation
//   o_busy    out  1  high while iterating (CALC) or fixing the sign (FIX)
//   o_valid   out  1  one-cycle result strobe (DONE)
//   o_result  out 32  quotient or remainder, held until the next DONE or reset
//
// Ports (add_sub):
//   i_a, i_b  in  32  operands
//   i_sub     in   1  1: i_a - i_b, 0: i_a + i_b
//   o_sum     out 32  result
//   o_cout    out  1  carry out (for subtraction: 1 means no borrow, i_a >= i_b)
// -----------------------------------------------------------------------------

module add_sub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] b_eff;

  // Subtraction is a + ~b + 1; the carry-in is the subtract flag itself.
  assign b_eff           = i_sub ? ~i_b : i_b;
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, b_eff} + {32'd0, i_sub};

endmodule

module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  op_t         op_q;
  logic [31:0] rem_q;        // partial remainder
  logic [31:0] quo_q;        // dividend bits shift out the top, quotient bits in
  logic [31:0] divisor_q;    // |divisor|
  logic [4:0]  count_q;      // steps remaining after the current one
  logic        neg_quo_q;    // quotient must be negated in FIX
  logic        neg_rem_q;    // remainder must be negated in FIX
  logic [31:0] result_q;

  // ---------------------------------------------------------------------------
  // Accept-side decode: operand magnitudes, result signs and special cases
  // ---------------------------------------------------------------------------
  op_t         op_in;
  logic        in_signed;
  logic        in_is_rem;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] abs_rs1;
  logic [31:0] abs_rs2;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;
  logic        can_accept;
  logic        accept;

  assign op_in     = op_t'(i_op);
  assign in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
  assign in_is_rem = (op_in == OP_REM) || (op_in == OP_REMU);

  assign rs1_neg = in_signed && i_rs1[31];
  assign rs2_neg = in_signed && i_rs2[31];

  // |INT_MIN| wraps to INT_MIN, which is still the correct unsigned magnitude.
  assign abs_rs1 = rs1_neg ? (32'd0 - i_rs1) : i_rs1;
  assign abs_rs2 = rs2_neg ? (32'd0 - i_rs2) : i_rs2;

  assign div_zero = (i_rs2 == 32'd0);
  assign overflow = in_signed && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES);
  assign special  = div_zero || overflow;

  // Division by zero wins over overflow (rs2 cannot be both zero and -1).
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    special_result = 32'd0;
    if (div_zero) begin
      special_result = in_is_rem ? i_rs1 : ALL_ONES;
    end else if (overflow) begin
      special_result = in_is_rem ? 32'd0 : INT_MIN;
    end
  end

  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept     = can_accept && i_start && !i_flush;

  // ---------------------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------------------
  logic [31:0] shifted;
  logic        msb_out;
  logic [31:0] diff;
  logic        diff_cout;
  logic        step_ok;

  assign shifted = {rem_q[30:0], quo_q[31]};
  // The bit shifted out of rem is the 33rd bit of the trial value. When it is
  // set the trial value exceeds any 32-bit divisor, so the step must succeed,
  // and the 32-bit difference is exact because the true result is < divisor.
  assign msb_out = rem_q[31];

  add_sub u_add_sub (
    .i_a    (shifted),
    .i_b    (divisor_q),
    .i_sub  (1'b1),
    .o_sum  (diff),
    .o_cout (diff_cout)
  );

  assign step_ok = msb_out || diff_cout;

  // ---------------------------------------------------------------------------
  // Sign fix-up
  // ---------------------------------------------------------------------------
  logic        fix_is_rem;
  logic [31:0] fix_sel;
  logic        fix_neg;
  logic [31:0] fix_value;

  assign fix_is_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign fix_sel    = fix_is_rem ? rem_q : quo_q;
  assign fix_neg    = fix_is_rem ? neg_rem_q : neg_quo_q;
  assign fix_value  = fix_neg ? (32'd0 - fix_sel) : fix_sel;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (count_q == 5'd0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        o_busy  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush overrides everything except reset, including a same-cycle start.
    if (i_flush) begin
      state_d = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: this block holds plain registers, not a memory array, so all of
      // them are cleared on reset and nothing downstream sees stale values.
      op_q      <= OP_DIV;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      divisor_q <= 32'd0;
      count_q   <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else if (!i_flush) begin
      if (accept) begin
        op_q      <= op_in;
        rem_q     <= 32'd0;
        quo_q     <= abs_rs1;
        divisor_q <= abs_rs2;
        count_q   <= 5'd31;
        neg_quo_q <= rs1_neg ^ rs2_neg;
        neg_rem_q <= rs1_neg;
        if (special) begin
          result_q <= special_result;
        end
      end else begin
        case (state_q)
          S_CALC: begin
            rem_q   <= step_ok ? diff : shifted;
            quo_q   <= {quo_q[30:0], step_ok};
            count_q <= count_q - 5'd1;
          end
          S_FIX: begin
            result_q <= fix_value;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
//
// Directed scenarios (reset, signed/unsigned, special cases, wide divisor,
// flush, start while busy, back-to-back start, mid-operation reset) followed
// by randomized operations. Expected results come from a reference function
// built on SystemVerilog's own signed/unsigned division with the RISC-V
// special-case rules layered on top.
// -----------------------------------------------------------------------------

module tb_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  div_unit dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case something below never returns.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      DIVU: return a / b;
      REMU: return a % b;
      DIV: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      default: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to the next cycle: one rising edge, then settle before sampling.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one operation from an idle/done state and follow it to completion.
  // Returns with the bench sitting in the cycle after DONE.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    int          busy_bad;
    exp     = ref_result(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 34;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    // Operands must only matter on the accept edge.
    i_rs1   = $urandom;
    i_rs2   = $urandom;
    i_op    = 2'($urandom_range(0, 3));
    lat      = 1;
    busy_bad = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      if (o_busy !== 1'b1) busy_bad++;
      step();
      lat++;
    end
    check({tag, " busy_while_running"}, busy_bad, 0);
    check({tag, " valid"}, o_valid, 1'b1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, o_result, exp);
    check({tag, " busy_in_done"}, o_busy, 1'b0);
    step();
    check({tag, " valid_pulse"}, o_valid, 1'b0);
    check({tag, " result_held"}, o_result, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] prev;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          bad;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_rs1   = 32'd0;
    i_rs2   = 32'd0;
    i_flush = 1'b0;

    // Reset state.
    step();
    step();
    check("reset busy", o_busy, 1'b0);
    check("reset valid", o_valid, 1'b0);
    check("reset result", o_result, 32'd0);
    i_rst = 1'b0;
    step();

    // Basic unsigned and signed.
    do_op("divu_100_7", DIVU, 32'd100, 32'd7);
    do_op("remu_100_7", REMU, 32'd100, 32'd7);
    do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE);

    // Special cases.
    do_op("div_5_0", DIV, 32'd5, 32'd0);
    do_op("remu_5_0", REMU, 32'd5, 32'd0);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);

    // Wide divisor.
    do_op("divu_wide", DIVU, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("remu_wide", REMU, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("divu_max_max", DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush in cycle 10 with a same-cycle start: busy drops next cycle,
    // nothing is produced, the previous result is kept.
    prev    = o_result;
    i_op    = DIVU;
    i_rs1   = 32'd1000;
    i_rs2   = 32'd3;
    i_start = 1'b1;
    step();                       // cycle 1
    i_start = 1'b0;
    repeat (9) step();            // cycle 10
    check("flush busy_before", o_busy, 1'b1);
    i_flush = 1'b1;
    i_start = 1'b1;
    step();                       // cycle 11
    i_flush = 1'b0;
    i_start = 1'b0;
    check("flush busy_after", o_busy, 1'b0);
    check("flush valid_after", o_valid, 1'b0);
    check("flush result_kept", o_result, prev);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_valid !== 1'b0 || o_busy !== 1'b0) bad++;
      step();
    end
    check("flush stays_idle", bad, 0);
    check("flush result_kept_later", o_result, prev);
    do_op("after_flush", DIVU, 32'd1000, 32'd3);

    // Start while busy is ignored; a start in DONE is accepted back-to-back.
    i_op    = DIVU;
    i_rs1   = 32'd100;
    i_rs2   = 32'd7;
    i_start = 1'b1;
    step();                       // cycle 1
    i_start = 1'b0;
    repeat (4) step();            // cycle 5
    i_op    = DIV;
    i_rs1   = 32'd12345;
    i_rs2   = 32'd3;
    i_start = 1'b1;
    step();                       // cycle 6
    i_start = 1'b0;
    lat = 6;
    while (o_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check("midstart latency", lat, 34);
    check("midstart result", o_result, 32'd14);
    // In DONE (cycle 34): issue the second op.
    i_op    = REMU;
    i_rs1   = 32'd1000;
    i_rs2   = 32'd7;
    i_start = 1'b1;
    step();                       // cycle 35
    i_start = 1'b0;
    check("b2b busy", o_busy, 1'b1);
    check("b2b valid_low", o_valid, 1'b0);
    lat = 35;
    while (o_valid !== 1'b1 && lat < 80) begin
      step();
      lat++;
    end
    check("b2b latency", lat, 68);
    check("b2b result", o_result, 32'd6);
    step();

    // Reset in cycle 20 of an operation.
    i_op    = DIVU;
    i_rs1   = 32'hFFFF_FFFF;
    i_rs2   = 32'd3;
    i_start = 1'b1;
    step();                       // cycle 1
    i_start = 1'b0;
    repeat (19) step();           // cycle 20
    check("rst busy_before", o_busy, 1'b1);
    i_rst = 1'b1;
    step();                       // cycle 21
    i_rst = 1'b0;
    check("rst busy", o_busy, 1'b0);
    check("rst valid", o_valid, 1'b0);
    check("rst result", o_result, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid !== 1'b0 || o_busy !== 1'b0) bad++;
      step();
    end
    check("rst stays_idle", bad, 0);

    // Randomized operations, biased toward corner operands.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'h8000_0000 | 32'($urandom);
        4: begin
          ra = 32'($urandom_range(0, 50));
          rb = $urandom;
        end
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", n), rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, placed in the execute stage beside the ALU. It instantiates one `add_sub` in subtract mode and computes one quotient bit per cycle (restoring division). The unit holds the pipeline via `o_busy` and returns its result with a one-cycle `o_valid` pulse. Sign handling and RISC-V special cases are resolved inside the block.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request a new operation; accepted only in IDLE or DONE.
- `i_op`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i_rs1`  in  32  dividend; sampled on the accept edge only.
- `i_rs2`  in  32  divisor; sampled on the accept edge only.
- `i_flush`  in  1  abort the current operation (pipeline kill).
- `o_busy`  out  1  high in CALC and FIX.
- `o_valid`  out  1  one-cycle pulse, high in DONE.
- `o_result`  out  32  quotient or remainder; holds its value until the next DONE or reset.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Control priority per edge:** `i_rst`, then `i_flush`, then `i_start`.
- **Accept (IDLE or DONE with `i_start`=1):**
  - Latch `i_op`.
  - Signed ops: latch |rs1| and |rs2|, and record the result sign.
    - Quotient negative when the operand signs differ.
    - Remainder takes the dividend's sign.
  - Unsigned ops: latch operands unchanged.
  - Clear rem; set quo to |dividend|; set count to 31.
- **Special cases, detected at accept (skip CALC and FIX, go straight to DONE):**
  - Divisor = 0: quotient 0xFFFFFFFF; remainder = `i_rs1` unchanged.
  - Signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **CALC, one step per cycle:**
  - Form shifted = {rem[30:0], quo[31]}; msb_out = rem[31].
  - `add_sub` computes shifted − |divisor| (`i_sub`=1).
  - Step succeeds when msb_out | `o_cout`.
    - Success: rem ← `o_sum`; quo ← {quo[30:0], 1}.
    - Failure: rem ← shifted; quo ← {quo[30:0], 0}.
  - msb_out covers 33-bit intermediates when the unsigned divisor is ≥ 0x80000000.
  - count decrements each step; at count = 0 go to FIX.
- **FIX:**
  - Select quo (DIV/DIVU) or rem (REM/REMU).
  - Two's-complement negate the selection if the recorded sign requires it.
  - Register the result; go to DONE.
- **DONE:**
  - `o_valid`=1 and `o_result` is stable.
  - Next state is IDLE, or an accept if `i_start`=1.
- **Flush:** `i_flush` in any state → IDLE on the next edge.
  - No `o_valid` is produced.
  - `o_result` keeps its previous value.
  - A same-cycle `i_start` is ignored.
- **`i_start` in CALC or FIX:** ignored; no queuing.

## Timing
- **Reset:** state IDLE; `o_busy`=0, `o_valid`=0, `o_result`=0; internal registers cleared.
- **Normal latency** (`i_start` sampled at edge 0):
  - CALC occupies cycles 1–32.
  - FIX occupies cycle 33.
  - DONE is cycle 34: `o_valid`=1 and `o_result` valid.
- **Special-case latency:** DONE in cycle 1.
- **`o_busy`:** 1 in cycles 1–33; 0 in DONE, so back-to-back issue is possible.
  - A start accepted in DONE makes `o_busy`=1 in the following cycle.
- **Reset or flush mid-CALC:** takes effect at the next edge; `o_busy`=0 from that cycle.
- **`o_valid`:** never high for two consecutive cycles unless a special-case op is accepted in DONE.

## Test plan
- **DIVU 100 / 7:** start at edge 0 → `o_busy` high in cycles 1–33; `o_valid`=1 in cycle 34 with `o_result`=14. REMU on the same operands → 2.
- **Signed:**
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - REM 7 / −2 → 1.
- **Special cases, all with `o_valid` in cycle 1:**
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM on the same operands → 0.
- **Wide divisor:**
  - DIVU 0xFFFFFFFF / 0x80000000 → 1.
  - REMU on the same operands → 0x7FFFFFFF (exercises msb_out).
  - DIVU 0xFFFFFFFF / 0xFFFFFFFF → 1.
- **Flush:** assert `i_flush` in cycle 10 of a DIVU → `o_busy`=0 from cycle 11, no `o_valid`, `o_result` unchanged. A new start in cycle 11 completes with `o_valid` in cycle 45.
- **Mid-operation start and reset:**
  - Pulse `i_start` with different operands in cycle 5 → ignored; the cycle-34 result belongs to the first op.
  - A second start in DONE (cycle 34) → second `o_valid` in cycle 68.
  - `i_rst` in cycle 20 → all outputs 0 from cycle 21.
